mult_sequencer: RTL and testbench
=================================

# mult_sequencer

Cycle-accurate control sequencer for the N-bit add-shift multiplier datapath (X/A/B registers, adder/subtractor, multiplicand S). It synchronises and edge-detects the Run and Load_Clear buttons, then drives one-hot control strobes to the register unit: clear/load, N add/subtract phases, N shift phases and a done indication. Iteration count comes from a counter, not from unrolled per-bit states. The block sits between the top-level button inputs and the register/adder unit.

## Interface
- N, default 8: operand width; number of add/shift iterations.
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  asynchronous button level; a rising edge starts one multiply.
- Load_Clear  input  1  asynchronous button level; a rising edge loads B and clears X:A.
- M  input  1  current B[0] from the datapath (multiplier LSB), sampled combinationally.
- Clr_XA  output  1  clear X and A this cycle.
- Ld_B  output  1  load B from switches this cycle.
- Add  output  1  A <= A + S, X <= sign of the sum.
- Sub  output  1  A <= A - S, X <= sign of the result.
- Shift  output  1  arithmetic right shift of X:A:B by one bit.
- Busy  output  1  a multiply is in progress.
- Done  output  1  the multiply is complete; the result is valid in A:B.

## Operation
- Run and Load_Clear each pass through a 2-FF synchroniser plus a third edge register. An edge is sync2 & ~sync3.
- States: IDLE, LOAD, CLR, ADD, SHIFT, DONE. Iteration counter cnt has width $clog2(N).
- IDLE: all strobes 0.
  - Run edge goes to CLR.
  - Otherwise, Load_Clear edge goes to LOAD.
  - If both edges occur in the same cycle, Run wins and the Load_Clear edge is dropped.
- LOAD: Ld_B=1 and Clr_XA=1 for exactly one cycle, then go to IDLE.
- CLR: Clr_XA=1 for one cycle; cnt <= 0; go to ADD.
- ADD: one cycle, always entered (fixed latency).
  - For cnt < N-1: Add=M.
  - For cnt = N-1: Sub=M.
  - If M=0, no arithmetic strobe is asserted.
  - Go to SHIFT.
- SHIFT: Shift=1 for one cycle.
  - If cnt = N-1, go to DONE.
  - Otherwise cnt <= cnt+1 and go to ADD.
- DONE: Done=1; remain until the synchronised Run level is 0, then go to IDLE. A held button therefore never restarts.
- Busy=1 in CLR, ADD and SHIFT; 0 elsewhere.
- Edges arriving while in CLR, ADD, SHIFT or DONE are ignored, not queued.
- At most one of Clr_XA, Add, Sub, Shift is high in any cycle. The only exception is Clr_XA with Ld_B in LOAD.
- All outputs are Moore outputs decoded from state. Add and Sub are additionally gated by M.

## Timing
- Reset values:
  - state = IDLE and cnt = 0.
  - All outputs are 0.
  - Synchroniser and edge flops are reset to 1, so a button held through Reset produces no edge.
- Reset asserted mid-operation: next cycle is IDLE, all strobes drop, and the datapath is left as-is.
- Run rising at the pins is seen as an edge 3 Clk cycles later (Run edge at cycle t). Then:
  - CLR at t+1.
  - First ADD at t+2.
  - Last SHIFT at t+1+2N.
  - Done first high at t+2+2N (t+18 for N=8).
- Multiply occupancy is 1 + 2N cycles of Busy.
- LOAD occupies exactly one cycle, one cycle after the Load_Clear edge.
- M is sampled in the ADD cycle. The datapath must present the shifted B[0] by the cycle after each SHIFT.

## Structure
- Package mult_pkg:
  - state enum type mult_state_t {IDLE, LOAD, CLR, ADD, SHIFT, DONE}.
  - Default width constant MULT_N = 8.
- Sub-module btn_sync_edge: 2-FF synchroniser plus edge register, synchronous reset to 1, outputs level and rise. It is instantiated twice, for Run and Load_Clear.
- The top level holds the state register, cnt, next-state logic and output decode.

## Test plan
- Reset, then Load_Clear pulse: Ld_B=Clr_XA=1 for exactly one cycle 4 cycles after the pulse; Busy stays 0.
- N=8, M stream 1,0,1,0,0,0,0,0: Add high only in ADD iterations 0 and 2, Sub never, 8 Shift pulses, Done at t+18, Busy high 17 cycles.
- M=1 in all iterations (negative multiplier): Add in iterations 0–6 and Sub only in iteration 7; never Add and Sub together.
- Run held high for 40 cycles: exactly one multiply; Done stays high until Run falls, then IDLE 3 cycles later; no second CLR.
- Run pulsed during ADD iteration 3: ignored; sequence and Done timing unchanged.
- Reset asserted during SHIFT iteration 5 with Run held: outputs 0 next cycle and no restart after Reset falls. Run and Load_Clear edges in the same cycle: CLR is entered, and no Ld_B occurs.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared state encoding and default width for the add-shift
//             multiplier control sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_N = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLR   = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } mult_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : btn_sync_edge
//  Purpose  : Two-flop synchroniser plus edge register for a button level;
//             provides the synchronised level and a one-cycle rise pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_sync_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    // [0] first sync stage, [1] second sync stage, [2] edge history
    logic [2:0] sync_q;

    // Reset to all ones so a button held through reset never looks like a press.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], btn_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];

endmodule : btn_sync_edge
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mult_sequencer
//  Purpose  : Control sequencer for the N-bit add-shift multiplier; turns
//             Run/Load_Clear presses into one-hot register-unit strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic load_clear_i,
    input  logic m_i,
    output logic clr_xa_o,
    output logic ld_b_o,
    output logic add_o,
    output logic sub_o,
    output logic shift_o,
    output logic busy_o,
    output logic done_o
);

    localparam int              CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

    mult_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic run_level;
    logic run_rise;
    logic lc_level_unused;
    logic lc_rise;

    btn_sync_edge u_run_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (run_i),
        .level_o (run_level),
        .rise_o  (run_rise)
    );

    btn_sync_edge u_lc_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (load_clear_i),
        .level_o (lc_level_unused),
        .rise_o  (lc_rise)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_xa_o = 1'b0;
        ld_b_o   = 1'b0;
        add_o    = 1'b0;
        sub_o    = 1'b0;
        shift_o  = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Run has priority; a simultaneous Load_Clear press is dropped.
                if (run_rise) begin
                    state_d = CLR;
                end else if (lc_rise) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_b_o   = 1'b1;
                clr_xa_o = 1'b1;
                state_d  = IDLE;
            end
            CLR: begin
                clr_xa_o = 1'b1;
                busy_o   = 1'b1;
                cnt_d    = '0;
                state_d  = ADD;
            end
            ADD: begin
                busy_o = 1'b1;
                // Final iteration subtracts: the multiplier MSB carries negative weight.
                if (cnt_q == CNT_LAST) begin
                    sub_o = m_i;
                end else begin
                    add_o = m_i;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_o = 1'b1;
                busy_o  = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ADD;
                end
            end
            DONE: begin
                done_o = 1'b1;
                if (!run_level) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : mult_sequencer
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_sequencer
//  Purpose  : Scoreboard bench for mult_sequencer; expected per-cycle strobes
//             come from a timeline model of each press.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;

    localparam int N = 8;

    // Expected word layout: {clr, ldb, add, sub, shift, busy, done}
    typedef struct packed {
        logic       rst;
        logic       run;
        logic       lc;
        logic       m;
        logic [6:0] exp;
    } step_t;

    logic clk_i = 1'b0;
    logic reset_i;
    logic run_i;
    logic load_clear_i;
    logic m_i;
    logic clr_xa_o, ld_b_o, add_o, sub_o, shift_o, busy_o, done_o;

    step_t      sq[$];
    logic [6:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    mult_sequencer #(.N(N)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .run_i        (run_i),
        .load_clear_i (load_clear_i),
        .m_i          (m_i),
        .clr_xa_o     (clr_xa_o),
        .ld_b_o       (ld_b_o),
        .add_o        (add_o),
        .sub_o        (sub_o),
        .shift_o      (shift_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic push_step(input logic rs, input logic rn, input logic lc,
                             input logic mv, input logic [6:0] e);
        step_t s;
        s.rst = rs; s.run = rn; s.lc = lc; s.m = mv; s.exp = e;
        sq.push_back(s);
    endtask

    task automatic idle_steps(input int n, input logic rs);
        for (int k = 0; k < n; k++) push_step(rs, 1'b0, 1'b0, 1'($urandom()), 7'd0);
    endtask

    // Load_Clear held for 'hold' cycles: a single Ld_B+Clr_XA cycle three cycles on.
    task automatic load_scn(input int hold);
        for (int r = 0; r < hold + 5; r++)
            push_step(1'b0, 1'b0, (r < hold), 1'($urandom()),
                      (r == 3) ? 7'b1100000 : 7'd0);
    endtask

    // One multiply from a Run press at relative cycle 0. pulse_at adds a
    // one-cycle Run re-press, lc_too presses Load_Clear together with Run,
    // rst_at asserts Reset for two cycles (negative = unused).
    task automatic mult_scn(input logic [N-1:0] mb, input int hold, input int pulse_at,
                            input bit lc_too, input int rst_at);
        int         d;
        int         done_end;
        int         len;
        int         i;
        logic       mv;
        logic [6:0] e;
        d        = 4 + 2 * N;
        done_end = (hold + 2 > d) ? hold + 2 : d;
        len      = done_end + 4;
        for (int r = 0; r < len; r++) begin
            e  = 7'd0;
            mv = 1'($urandom());
            if (r == 3) e = 7'b1000010;
            if (r >= 4 && r < 4 + 2 * N) begin
                i = (r - 4) / 2;
                if (((r - 4) % 2) == 0) begin
                    mv = mb[i];
                    if (mv) e = (i == N - 1) ? 7'b0001010 : 7'b0010010;
                    else    e = 7'b0000010;
                end else begin
                    e = 7'b0000110;
                end
            end
            if (r >= d && r <= done_end) e = 7'b0000001;
            if (rst_at >= 0 && r > rst_at) e = 7'd0;
            push_step((rst_at >= 0) && (r == rst_at || r == rst_at + 1),
                      (r < hold) || (r == pulse_at),
                      lc_too && (r < 2), mv, e);
        end
    endtask

    always @(negedge clk_i) begin
        logic [6:0] act;
        logic [6:0] e;
        cyc <= cyc + 1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {clr_xa_o, ld_b_o, add_o, sub_o, shift_o, busy_o, done_o};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL outs@cyc%0d: got clr,ldb,add,sub,shift,busy,done=%b expected %b",
                         cyc, act, e);
            end
        end
    end

    initial begin
        reset_i      = 1'b1;
        run_i        = 1'b0;
        load_clear_i = 1'b0;
        m_i          = 1'b0;

        idle_steps(3, 1'b1);
        idle_steps(4, 1'b0);
        load_scn(2);
        mult_scn(8'b0000_0101, 2, -1, 1'b0, -1);
        mult_scn(8'hFF, 3, -1, 1'b0, -1);
        mult_scn(8'h5A, 40, -1, 1'b0, -1);
        mult_scn(8'h93, 2, 10, 1'b0, -1);
        mult_scn(8'hC3, 30, -1, 1'b0, 15);
        idle_steps(3, 1'b0);
        mult_scn(8'h81, 4, -1, 1'b1, -1);
        for (int t = 0; t < 6; t++) begin
            mult_scn(N'($urandom()), int'($urandom_range(1, 30)), -1, 1'b0, -1);
            load_scn(int'($urandom_range(1, 6)));
            idle_steps(int'($urandom_range(0, 4)), 1'b0);
        end

        foreach (sq[k]) begin
            @(posedge clk_i);
            #1;
            reset_i      = sq[k].rst;
            run_i        = sq[k].run;
            load_clear_i = sq[k].lc;
            m_i          = sq[k].m;
            exp_q.push_back(sq[k].exp);
        end
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult_sequencer
`default_nettype wire
